// File: rtl/pad_pkg.sv
// Shared definitions for the multi-pad Genesis-style scanner: button indices,
// pin positions, sequencer states and small helpers.
package pad_pkg;

  localparam int BTN_W = 12;
  localparam int PIN_W = 6;

  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;
  localparam int BTN_A     = 4;
  localparam int BTN_B     = 5;
  localparam int BTN_C     = 6;
  localparam int BTN_START = 7;
  localparam int BTN_X     = 8;
  localparam int BTN_Y     = 9;
  localparam int BTN_Z     = 10;
  localparam int BTN_MODE  = 11;

  localparam int PIN_UP_Z    = 0;
  localparam int PIN_DOWN_Y  = 1;
  localparam int PIN_LEFT_X  = 2;
  localparam int PIN_RIGHT   = 3;
  localparam int PIN_A_B     = 4;
  localparam int PIN_START_C = 5;

  typedef enum logic [3:0] {
    IDLE = 4'd0,
    PH0  = 4'd8,
    PH1  = 4'd9,
    PH2  = 4'd10,
    PH3  = 4'd11,
    PH4  = 4'd12,
    PH5  = 4'd13,
    PH6  = 4'd14,
    PH7  = 4'd15
  } seq_state_e;

  // Select is high while idle and during even phases.
  function automatic logic select_level(input seq_state_e st);
    logic lvl;
    case (st)
      IDLE, PH0, PH2, PH4, PH6: lvl = 1'b1;
      PH1, PH3, PH5, PH7:       lvl = 1'b0;
      default:                  lvl = 1'b1;
    endcase
    return lvl;
  endfunction

  function automatic seq_state_e next_phase(input seq_state_e st);
    seq_state_e nxt;
    case (st)
      PH0:     nxt = PH1;
      PH1:     nxt = PH2;
      PH2:     nxt = PH3;
      PH3:     nxt = PH4;
      PH4:     nxt = PH5;
      PH5:     nxt = PH6;
      PH6:     nxt = PH7;
      PH7:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
    return nxt;
  endfunction

  // Two-scan agreement: a bit follows raw only when raw matches the previous scan.
  function automatic logic [BTN_W-1:0] debounce(input logic [BTN_W-1:0] raw,
                                                input logic [BTN_W-1:0] hist,
                                                input logic [BTN_W-1:0] cur);
    logic [BTN_W-1:0] agree;
    agree = ~(raw ^ hist);
    return (raw & agree) | (cur & ~agree);
  endfunction

endpackage

// File: rtl/pad_decode.sv
// Per-pad front end: pin synchroniser, phase samplers, presence/6-button
// detection, debounce history and press-edge detection.
module pad_decode
  import pad_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [PIN_W-1:0] i_pins,
  input  seq_state_e       i_state,
  input  logic             i_sample,
  input  logic             i_commit,
  output logic [BTN_W-1:0] o_buttons,
  output logic [BTN_W-1:0] o_pulse,
  output logic             o_connected,
  output logic             o_six_btn
);

  logic [PIN_W-1:0] r_sync1;
  logic [PIN_W-1:0] r_sync2;
  logic [BTN_W-1:0] r_smp;
  logic             r_conn_smp;
  logic             r_six_smp;
  logic [BTN_W-1:0] r_hist;
  logic [BTN_W-1:0] r_btn;
  logic [BTN_W-1:0] r_pulse;
  logic             r_conn;
  logic             r_six;
  logic [PIN_W-1:0] w_act;
  logic [BTN_W-1:0] w_raw;
  logic [BTN_W-1:0] w_btn_nxt;

  // Two-flop synchroniser; idle pins read high (no pad).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 6'h3F;
      r_sync2 <= 6'h3F;
    end else begin
      r_sync1 <= i_pins;
      r_sync2 <= r_sync1;
    end
  end

  assign w_act = ~r_sync2;

  // Capture each phase's pins on the strobe marking its last cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_smp      <= 12'h000;
      r_conn_smp <= 1'b0;
      r_six_smp  <= 1'b0;
    end else if (i_sample) begin
      case (i_state)
        PH0: begin
          r_smp[BTN_UP]    <= w_act[PIN_UP_Z];
          r_smp[BTN_DOWN]  <= w_act[PIN_DOWN_Y];
          r_smp[BTN_LEFT]  <= w_act[PIN_LEFT_X];
          r_smp[BTN_RIGHT] <= w_act[PIN_RIGHT];
          r_smp[BTN_B]     <= w_act[PIN_A_B];
          r_smp[BTN_C]     <= w_act[PIN_START_C];
        end
        PH1: begin
          r_smp[BTN_A]     <= w_act[PIN_A_B];
          r_smp[BTN_START] <= w_act[PIN_START_C];
          r_conn_smp       <= (r_sync2[PIN_LEFT_X] == 1'b0) && (r_sync2[PIN_RIGHT] == 1'b0);
        end
        PH5: begin
          r_six_smp <= (r_sync2[PIN_RIGHT:PIN_UP_Z] == 4'b0000);
        end
        PH6: begin
          r_smp[BTN_Z]    <= w_act[PIN_UP_Z];
          r_smp[BTN_Y]    <= w_act[PIN_DOWN_Y];
          r_smp[BTN_X]    <= w_act[PIN_LEFT_X];
          r_smp[BTN_MODE] <= w_act[PIN_RIGHT];
        end
        default: begin
          r_smp <= r_smp;
        end
      endcase
    end
  end

  // Extended buttons only count on a 6-button pad; nothing counts without a pad.
  always_comb begin
    w_raw     = 12'h000;
    w_btn_nxt = r_btn;
    if (r_conn_smp) begin
      if (r_six_smp) begin
        w_raw = r_smp;
      end else begin
        w_raw = {4'b0000, r_smp[BTN_START:BTN_UP]};
      end
    end else begin
      w_raw = 12'h000;
    end
    w_btn_nxt = debounce(w_raw, r_hist, r_btn);
  end

  // Commit the scan; press pulses last only the commit cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hist  <= 12'h000;
      r_btn   <= 12'h000;
      r_pulse <= 12'h000;
      r_conn  <= 1'b0;
      r_six   <= 1'b0;
    end else if (i_commit) begin
      r_hist  <= w_raw;
      r_btn   <= w_btn_nxt;
      r_pulse <= w_btn_nxt & ~r_btn;
      r_conn  <= r_conn_smp;
      r_six   <= r_six_smp;
    end else begin
      r_pulse <= 12'h000;
    end
  end

  assign o_buttons   = r_btn;
  assign o_pulse     = r_pulse;
  assign o_connected = r_conn;
  assign o_six_btn   = r_six;

endmodule

// File: rtl/pad_scanner.sv
// Shared-select multi-pad scanner: scan-rate divider, 8-phase select sequencer
// and one pad_decode per pad.
module pad_scanner
  import pad_pkg::*;
#(
  parameter int NUM_PADS     = 1,
  parameter int PHASE_CYCLES = 1000,
  parameter int SCAN_DIV     = 833333
) (
  input  logic                      clock_50,
  input  logic                      reset_key,
  input  logic                      scan_enable,
  input  logic [6*NUM_PADS-1:0]     pad_in,
  output logic                      select_out,
  output logic [12*NUM_PADS-1:0]    buttons,
  output logic [12*NUM_PADS-1:0]    pressed_pulse,
  output logic [NUM_PADS-1:0]       connected,
  output logic [NUM_PADS-1:0]       six_btn,
  output logic                      scan_done
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int PH_W  = $clog2(PHASE_CYCLES);

  logic [DIV_W-1:0] r_div;
  logic [PH_W-1:0]  r_ph_cnt;
  seq_state_e       r_state;
  seq_state_e       w_state_nxt;
  logic             r_sel;
  logic             r_done;
  logic             w_wrap;
  logic             w_start;
  logic             w_last;
  logic             w_commit;

  assign w_wrap   = (r_div == DIV_W'(SCAN_DIV - 1));
  assign w_start  = w_wrap && scan_enable;
  assign w_last   = (r_state != IDLE) && (r_ph_cnt == PH_W'(PHASE_CYCLES - 1));
  assign w_commit = (r_state == PH7) && w_last;

  // Scan-rate divider, parked at zero while scanning is disabled.
  always_ff @(posedge clock_50 or negedge reset_key) begin
    if (!reset_key) begin
      r_div <= {DIV_W{1'b0}};
    end else if (!scan_enable || w_wrap) begin
      r_div <= {DIV_W{1'b0}};
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  // Cycle-within-phase counter; zero on entry to every phase.
  always_ff @(posedge clock_50 or negedge reset_key) begin
    if (!reset_key) begin
      r_ph_cnt <= {PH_W{1'b0}};
    end else if ((r_state == IDLE) || w_last) begin
      r_ph_cnt <= {PH_W{1'b0}};
    end else begin
      r_ph_cnt <= r_ph_cnt + PH_W'(1);
    end
  end

  // Sequencer next state.
  always_comb begin
    w_state_nxt = r_state;
    if (r_state == IDLE) begin
      if (w_start) begin
        w_state_nxt = PH0;
      end else begin
        w_state_nxt = IDLE;
      end
    end else if (w_last) begin
      w_state_nxt = next_phase(r_state);
    end else begin
      w_state_nxt = r_state;
    end
  end

  // Select is registered from the next state so it moves with the phase.
  always_ff @(posedge clock_50 or negedge reset_key) begin
    if (!reset_key) begin
      r_state <= IDLE;
      r_sel   <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= select_level(w_state_nxt);
      r_done  <= w_commit;
    end
  end

  assign select_out = r_sel;
  assign scan_done  = r_done;

  for (genvar k = 0; k < NUM_PADS; k++) begin : g_pad
    pad_decode u_decode (
      .i_clk       (clock_50),
      .i_rst_n     (reset_key),
      .i_pins      (pad_in[6*k +: 6]),
      .i_state     (r_state),
      .i_sample    (w_last),
      .i_commit    (w_commit),
      .o_buttons   (buttons[12*k +: 12]),
      .o_pulse     (pressed_pulse[12*k +: 12]),
      .o_connected (connected[k]),
      .o_six_btn   (six_btn[k])
    );
  end

endmodule

// File: tb/tb_pad_scanner.sv
// Scoreboard bench for pad_scanner: behavioural Genesis pads drive the pins,
// per-scan expectations are queued and checked on each scan_done.
module tb_pad_scanner;

  localparam int NP = 2;
  localparam int PC = 4;
  localparam int SD = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [11:0] pad_in;
  logic        sel;
  logic [23:0] btn;
  logic [23:0] pulse;
  logic [1:0]  conn;
  logic [1:0]  six;
  logic        done;

  always #5 clk = ~clk;

  pad_scanner #(.NUM_PADS(NP), .PHASE_CYCLES(PC), .SCAN_DIV(SD)) dut (
    .clock_50      (clk),
    .reset_key     (rst_n),
    .scan_enable   (en),
    .pad_in        (pad_in),
    .select_out    (sel),
    .buttons       (btn),
    .pressed_pulse (pulse),
    .connected     (conn),
    .six_btn       (six),
    .scan_done     (done)
  );

  typedef struct {
    logic [23:0] btn;
    logic [23:0] pulse;
    logic [1:0]  conn;
    logic [1:0]  six;
  } exp_t;

  typedef struct {
    int          k0;
    logic [11:0] b0;
    int          k1;
    logic [11:0] b1;
    logic [23:0] btn;
    logic [23:0] pulse;
    logic [1:0]  conn;
    logic [1:0]  six;
  } vec_t;

  exp_t sb[$];
  vec_t vt[11];
  int   n_vec = 0;
  int   n_miss = 0;
  int   k0 = 0, k1 = 0;
  logic [11:0] b0 = 12'h000, b1 = 12'h000;
  int   n_low = 0;
  int   cyc;
  logic timing_chk = 1'b0;
  logic pulse_zero_chk = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Pad kind: 0 absent, 1 three-button, 2 six-button. b is active-high presses.
  function automatic logic [5:0] pad_pins(input int kind, input logic [11:0] b,
                                          input logic s, input int nl);
    logic [5:0] p;
    if (kind == 0) p = 6'h3F;
    else if (s && kind == 2 && nl == 3) p = ~{b[6], b[5], b[11], b[8], b[9], b[10]};
    else if (s) p = ~{b[6], b[5], b[3], b[2], b[1], b[0]};
    else if (kind == 2 && nl == 3) p = {~b[7], ~b[4], 4'b0000};
    else p = {~b[7], ~b[4], 2'b00, ~b[1], ~b[0]};
    return p;
  endfunction

  // Pads count select falls within a scan to know when extended data is due.
  always @(negedge sel or posedge done or negedge rst_n) begin
    if (!rst_n) n_low <= 0;
    else if (done) n_low <= 0;
    else n_low <= n_low + 1;
  end

  always_comb pad_in = {pad_pins(k1, b1, sel, n_low), pad_pins(k0, b0, sel, n_low)};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else cyc <= cyc + 1;
  end

  // Monitor: scoreboard pop on scan_done, pulse width, and free-run timing.
  always @(negedge clk) begin
    exp_t e;
    int m;
    logic sel_exp, done_exp;
    if (pulse_zero_chk) chk("pulse_width", pulse, 24'h0);
    pulse_zero_chk = 1'b0;
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_scan_done: got scan_done with no expectation at %0t", $time);
      end else begin
        e = sb.pop_front();
        chk("buttons", btn, e.btn);
        chk("pressed_pulse", pulse, e.pulse);
        chk("connected", conn, e.conn);
        chk("six_btn", six, e.six);
        pulse_zero_chk = 1'b1;
      end
    end
    if (timing_chk && rst_n) begin
      m = cyc % SD;
      if (cyc >= SD && m < 8 * PC) sel_exp = ((m / PC) % 2 == 0);
      else sel_exp = 1'b1;
      done_exp = (cyc >= SD + 8 * PC) && ((cyc - SD - 8 * PC) % SD == 0);
      chk("select_timing", sel, sel_exp);
      chk("scan_done_timing", done, done_exp);
    end
  end

  task automatic push_exp(input logic [23:0] eb, input logic [23:0] ep,
                          input logic [1:0] ec, input logic [1:0] es);
    exp_t e;
    e.btn = eb; e.pulse = ep; e.conn = ec; e.six = es;
    sb.push_back(e);
  endtask

  task automatic apply(input int i);
    k0 = vt[i].k0; b0 = vt[i].b0; k1 = vt[i].k1; b1 = vt[i].b1;
    push_exp(vt[i].btn, vt[i].pulse, vt[i].conn, vt[i].six);
  endtask

  task automatic wait_done(input int limit, output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!done && cycles < limit);
    if (!done) begin
      n_vec++;
      n_miss++;
      $display("FAIL scan_done_timeout: got none within %0d cycles at %0t", limit, $time);
    end
  endtask

  initial begin
    int c, q_done, q_low;
    // A = 0x010, left = 0x004, C = 0x040; pad1 holds Z (0x400) + start (0x080).
    vt[0]  = '{0, 12'h000, 0, 12'h000, 24'h000000, 24'h000000, 2'b00, 2'b00};
    vt[1]  = '{0, 12'h000, 0, 12'h000, 24'h000000, 24'h000000, 2'b00, 2'b00};
    vt[2]  = '{1, 12'h014, 0, 12'h000, 24'h000000, 24'h000000, 2'b01, 2'b00};
    vt[3]  = '{1, 12'h014, 0, 12'h000, 24'h000014, 24'h000014, 2'b01, 2'b00};
    vt[4]  = '{1, 12'h014, 0, 12'h000, 24'h000014, 24'h000000, 2'b01, 2'b00};
    vt[5]  = '{1, 12'h014, 2, 12'h480, 24'h000014, 24'h000000, 2'b11, 2'b10};
    vt[6]  = '{1, 12'h014, 2, 12'h480, 24'h480014, 24'h480000, 2'b11, 2'b10};
    vt[7]  = '{1, 12'h054, 2, 12'h480, 24'h480014, 24'h000000, 2'b11, 2'b10};
    vt[8]  = '{1, 12'h014, 2, 12'h480, 24'h480014, 24'h000000, 2'b11, 2'b10};
    vt[9]  = '{1, 12'h000, 2, 12'h480, 24'h480014, 24'h000000, 2'b11, 2'b10};
    vt[10] = '{1, 12'h000, 2, 12'h480, 24'h480000, 24'h000000, 2'b11, 2'b10};

    en = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_select", sel, 1'b1);
    chk("reset_buttons", btn, 24'h0);
    chk("reset_connected", conn, 2'b00);

    for (int i = 0; i < 11; i++) begin
      apply(i);
      if (i == 0) begin
        rst_n = 1'b1;
        timing_chk = 1'b1;
      end
      wait_done(2 * SD + 40, c);
    end
    timing_chk = 1'b0;

    // Drop enable mid-PH3: the scan still finishes and commits.
    repeat (45) @(negedge clk);
    chk("select_in_ph3", sel, 1'b0);
    push_exp(24'h480000, 24'h0, 2'b11, 2'b10);
    en = 1'b0;
    wait_done(40, c);
    chk("done_after_drop", c, 19);
    q_done = 0;
    q_low = 0;
    repeat (200) begin
      @(negedge clk);
      if (done) q_done++;
      if (!sel) q_low++;
    end
    chk("disabled_no_scan_done", q_done, 0);
    chk("disabled_select_high", q_low, 0);

    push_exp(24'h480000, 24'h0, 2'b11, 2'b10);
    en = 1'b1;
    wait_done(2 * SD + 40, c);
    chk("reenable_latency", c, SD + 8 * PC);

    // Reset in PH5 clears everything without a clock edge.
    repeat (52) @(negedge clk);
    chk("select_in_ph5", sel, 1'b0);
    chk("buttons_before_reset", btn, 24'h480000);
    #1 rst_n = 1'b0;
    #1;
    chk("async_reset_buttons", btn, 24'h0);
    chk("async_reset_pulse", pulse, 24'h0);
    chk("async_reset_connected", conn, 2'b00);
    chk("async_reset_six", six, 2'b00);
    chk("async_reset_done", done, 1'b0);
    chk("async_reset_select", sel, 1'b1);
    repeat (2) @(negedge clk);
    push_exp(24'h000000, 24'h0, 2'b11, 2'b10);
    rst_n = 1'b1;
    wait_done(2 * SD + 40, c);
    chk("post_reset_latency", c, SD + 8 * PC);

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
